// File: rtl/cam_transaction_monitor_pkg.sv
// Shared types for the CAM transaction monitor: record layout and field widths.
package cam_mon_types;

  localparam int KEY_W  = 16;
  localparam int VAL_W  = 16;
  localparam int TIME_W = 32;

  typedef enum logic [1:0] {
    TR_RESET = 2'd0,
    TR_WRITE = 2'd1,
    TR_READ  = 2'd2
  } tr_type_e;

  typedef struct packed {
    tr_type_e          tr_type;
    logic [KEY_W-1:0]  key;
    logic [VAL_W-1:0]  wdata;
    logic [VAL_W-1:0]  rdata;
    logic              valid_o;
    logic              hz_ww;
    logic              hz_wr;
    logic [TIME_W-1:0] ltime;
  } trans_t;

endpackage

// File: rtl/cam_transaction_monitor_if.sv
// Observed CAM handshake plus the downstream record stream of the monitor.
interface cam_transaction_monitor_if;
  import cam_mon_types::*;

  logic              dut_rst_i;
  logic              valid_i;
  logic              rw_n_i;
  logic [KEY_W-1:0]  key_i;
  logic [VAL_W-1:0]  val_i;
  logic              valid_o_obs;
  logic [VAL_W-1:0]  val_o_obs;
  logic              tr_valid;
  logic              tr_ready;
  trans_t            tr_data;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic [TIME_W-1:0] ltime_o;

  // master is the monitor: it observes the CAM and produces records.
  modport master (
    input  dut_rst_i, valid_i, rw_n_i, key_i, val_i, valid_o_obs, val_o_obs, tr_ready,
    output tr_valid, tr_data, overflow, drop_cnt, ltime_o
  );

  modport slave (
    output dut_rst_i, valid_i, rw_n_i, key_i, val_i, valid_o_obs, val_o_obs, tr_ready,
    input  tr_valid, tr_data, overflow, drop_cnt, ltime_o
  );

endinterface

// File: rtl/cam_transaction_monitor_fifo.sv
// Generic trans_t FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
module cam_mon_fifo
  import cam_mon_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  trans_t din,
  output trans_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  trans_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; empty pointers gate dout, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_transaction_monitor.sv
// Passive CAM monitor: turns observed reads/writes/DUT resets into timestamped records in a FIFO.
// Define CAM_MON_HAZARD_EN to compute write-write / write-read hazard flags from the last record.
module cam_transaction_monitor
  import cam_mon_types::*;
#(
  parameter int DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  cam_transaction_monitor_if.master bus
);

  logic [TIME_W-1:0] ltime;
  logic              dut_rst_q;
  logic              rec_valid;
  trans_t            rec;
  logic              full;
  logic              empty;
  logic              pop;
  logic              drop;

`ifdef CAM_MON_HAZARD_EN
  logic              hist_valid;
  tr_type_e          hist_type;
  logic [KEY_W-1:0]  hist_key;
  logic [VAL_W-1:0]  hist_wdata;
  logic [TIME_W-1:0] hist_ltime;
  logic              hist_adjacent;

  // A hazard needs the previous record to be a write, one cycle earlier, on the same key.
  assign hist_adjacent = hist_valid && (hist_type == TR_WRITE) &&
                         (hist_ltime + TIME_W'(1) == ltime) && (hist_key == bus.key_i);
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rec_valid = 1'b0;
    rec       = '0;
    rec.ltime = ltime;
    if (bus.dut_rst_i) begin
      if (!dut_rst_q) begin
        rec_valid   = 1'b1;
        rec.tr_type = TR_RESET;
      end
    end else if (bus.valid_i) begin
      rec_valid = 1'b1;
      rec.key   = bus.key_i;
      if (bus.rw_n_i) begin
        rec.tr_type = TR_READ;
        rec.rdata   = bus.val_o_obs;
        rec.valid_o = bus.valid_o_obs;
      end else begin
        rec.tr_type = TR_WRITE;
        rec.wdata   = bus.val_i;
      end
    end
`ifdef CAM_MON_HAZARD_EN
    if (rec_valid && hist_adjacent) begin
      rec.hz_wr = (rec.tr_type == TR_READ);
      rec.hz_ww = (rec.tr_type == TR_WRITE) && (rec.wdata != hist_wdata);
    end
`endif
  end

  assign pop  = bus.tr_ready && !empty;
  assign drop = rec_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ltime        <= '0;
      dut_rst_q    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      ltime     <= ltime + TIME_W'(1);
      dut_rst_q <= bus.dut_rst_i;
      if (drop) begin
        bus.overflow <= 1'b1;
        if (bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end
    end
  end

`ifdef CAM_MON_HAZARD_EN
  // History follows every captured record, including dropped ones; a DUT reset forgets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist_type  <= TR_RESET;
      hist_key   <= '0;
      hist_wdata <= '0;
      hist_ltime <= '0;
    end else if (rec_valid) begin
      hist_valid <= (rec.tr_type != TR_RESET);
      hist_type  <= rec.tr_type;
      hist_key   <= rec.key;
      hist_wdata <= rec.wdata;
      hist_ltime <= rec.ltime;
    end
  end
`endif

  cam_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rec_valid),
    .pop   (pop),
    .din   (rec),
    .dout  (bus.tr_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.tr_valid = !empty;
  assign bus.ltime_o  = ltime;

endmodule
